// File: rtl/cpu_pkg.sv
// CPU-wide constants shared by the execute stage.
//   - datapath / field widths
//   - ALU, memory and control opcodes
//   - exception codes
//   - multiplier FSM state type and the EX->MEM register layout
package cpu_pkg;
    localparam int ALU_OP_BUS  = 4;
    localparam int DAT_WIDTH   = 32;
    localparam int ADD_WIDTH   = 30;
    localparam int MEM_OP_BUS  = 2;
    localparam int CTRL_OP_BUS = 2;
    localparam int REG_ADD_BUS = 5;
    localparam int ISA_EXP_BUS = 3;

    localparam logic [ALU_OP_BUS-1:0] ALU_NOP  = 4'd0;
    localparam logic [ALU_OP_BUS-1:0] ALU_AND  = 4'd1;
    localparam logic [ALU_OP_BUS-1:0] ALU_OR   = 4'd2;
    localparam logic [ALU_OP_BUS-1:0] ALU_XOR  = 4'd3;
    localparam logic [ALU_OP_BUS-1:0] ALU_ADDS = 4'd4;
    localparam logic [ALU_OP_BUS-1:0] ALU_ADDU = 4'd5;
    localparam logic [ALU_OP_BUS-1:0] ALU_SUBS = 4'd6;
    localparam logic [ALU_OP_BUS-1:0] ALU_SUBU = 4'd7;
    localparam logic [ALU_OP_BUS-1:0] ALU_SHRL = 4'd8;
    localparam logic [ALU_OP_BUS-1:0] ALU_SHLL = 4'd9;
    localparam logic [ALU_OP_BUS-1:0] ALU_MULU = 4'd10;

    localparam logic [MEM_OP_BUS-1:0] MEM_NOP = 2'd0;
    localparam logic [MEM_OP_BUS-1:0] MEM_LDW = 2'd1;
    localparam logic [MEM_OP_BUS-1:0] MEM_STW = 2'd2;

    localparam logic [CTRL_OP_BUS-1:0] CTRL_NOP = 2'd0;
    localparam logic [CTRL_OP_BUS-1:0] CTRL_JMP = 2'd1;
    localparam logic [CTRL_OP_BUS-1:0] CTRL_BR  = 2'd2;

    localparam logic [ISA_EXP_BUS-1:0] EXP_NONE     = 3'd0;
    localparam logic [ISA_EXP_BUS-1:0] EXP_EXT_INT  = 3'd1;
    localparam logic [ISA_EXP_BUS-1:0] EXP_UNDEF    = 3'd2;
    localparam logic [ISA_EXP_BUS-1:0] EXP_OVF      = 3'd3;
    localparam logic [ISA_EXP_BUS-1:0] EXP_MISALIGN = 3'd4;
    localparam logic [ISA_EXP_BUS-1:0] EXP_TRAP     = 3'd5;
    localparam logic [ISA_EXP_BUS-1:0] EXP_PRIV     = 3'd6;

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]   pc;
        logic                   en;
        logic                   br_flag;
        logic [MEM_OP_BUS-1:0]  mem_op;
        logic [DAT_WIDTH-1:0]   mem_wr_data;
        logic [CTRL_OP_BUS-1:0] ctrl_op;
        logic [REG_ADD_BUS-1:0] dst_addr;
        logic                   gpr_wre;
        logic [ISA_EXP_BUS-1:0] exp_code;
        logic [DAT_WIDTH-1:0]   out;
    } ex_mem_t;
endpackage

// File: rtl/ex_stage_if.sv
// ID->EX bundle in, EX->MEM register plus forwarding/busy out.
//   master : upstream side (drives id_*, observes exe_*)
//   slave  : the execute stage
interface ex_stage_if;
    import cpu_pkg::*;
    logic [ADD_WIDTH-1:0]   id_pc_i;
    logic                   id_en_i;
    logic [ALU_OP_BUS-1:0]  id_alu_op_i;
    logic [DAT_WIDTH-1:0]   id_alu_in_0_i;
    logic [DAT_WIDTH-1:0]   id_alu_in_1_i;
    logic                   id_br_flag_i;
    logic [MEM_OP_BUS-1:0]  id_mem_op_i;
    logic [DAT_WIDTH-1:0]   id_mem_wr_data_i;
    logic [CTRL_OP_BUS-1:0] id_ctrl_op_i;
    logic [REG_ADD_BUS-1:0] id_dst_addr_i;
    logic                   id_gpr_wre_i;
    logic [ISA_EXP_BUS-1:0] id_exp_code_i;

    logic [DAT_WIDTH-1:0]   exe_fwd_data_o;
    logic                   exe_busy_o;
    logic [ADD_WIDTH-1:0]   exe_pc_o;
    logic                   exe_en_o;
    logic                   exe_br_flag_o;
    logic [MEM_OP_BUS-1:0]  exe_mem_op_o;
    logic [DAT_WIDTH-1:0]   exe_mem_wr_data_o;
    logic [CTRL_OP_BUS-1:0] exe_ctrl_op_o;
    logic [REG_ADD_BUS-1:0] exe_dst_addr_o;
    logic                   exe_gpr_wre_o;
    logic [ISA_EXP_BUS-1:0] exe_exp_code_o;
    logic [DAT_WIDTH-1:0]   exe_out_o;

    modport master (
        output id_pc_i, id_en_i, id_alu_op_i, id_alu_in_0_i, id_alu_in_1_i, id_br_flag_i,
               id_mem_op_i, id_mem_wr_data_i, id_ctrl_op_i, id_dst_addr_i, id_gpr_wre_i,
               id_exp_code_i,
        input  exe_fwd_data_o, exe_busy_o, exe_pc_o, exe_en_o, exe_br_flag_o, exe_mem_op_o,
               exe_mem_wr_data_o, exe_ctrl_op_o, exe_dst_addr_o, exe_gpr_wre_o,
               exe_exp_code_o, exe_out_o
    );
    modport slave (
        input  id_pc_i, id_en_i, id_alu_op_i, id_alu_in_0_i, id_alu_in_1_i, id_br_flag_i,
               id_mem_op_i, id_mem_wr_data_i, id_ctrl_op_i, id_dst_addr_i, id_gpr_wre_i,
               id_exp_code_i,
        output exe_fwd_data_o, exe_busy_o, exe_pc_o, exe_en_o, exe_br_flag_o, exe_mem_op_o,
               exe_mem_wr_data_o, exe_ctrl_op_o, exe_dst_addr_o, exe_gpr_wre_o,
               exe_exp_code_o, exe_out_o
    );
endinterface

// File: rtl/ex_stage_mul.sv
// ex_mul: 32-cycle shift-add unsigned multiplier (low word of product).
//   clk, rst : clock, async active-high reset
//   start    : MULU present in EX (sampled in IDLE)
//   flush    : abandon any operation, back to IDLE
//   hold     : result not yet consumed, stay in DONE
//   a, b     : operands
//   busy     : no finished product available yet (state != DONE)
//   done     : product valid
//   product  : low DAT_WIDTH bits of a*b
module ex_mul
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 flush,
    input  logic                 hold,
    input  logic [DAT_WIDTH-1:0] a,
    input  logic [DAT_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DAT_WIDTH-1:0] product
);
    mul_state_e           state, state_nxt;
    logic [4:0]           cnt;
    logic [DAT_WIDTH-1:0] acc, mcand, mplier;

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start)       state_nxt = MUL_RUN;
            MUL_RUN:  if (cnt == 5'd31) state_nxt = MUL_DONE;
            MUL_DONE: if (!hold)       state_nxt = MUL_IDLE;
            default:                   state_nxt = MUL_IDLE;
        endcase
        if (flush) state_nxt = MUL_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == MUL_IDLE && start) begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= '0;
            end else if (state == MUL_RUN) begin
                // Only the low word is kept, so the multiplicand simply shifts out the top.
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
            end
        end
    end

    assign busy    = (state != MUL_DONE);
    assign done    = (state == MUL_DONE);
    assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Evaluates the ALU op, merges overflow into the
// exception code and registers the EX->MEM bundle.
//   clk_i, rst_i : clock, async active-high reset
//   stall_i      : hold the EX->MEM register
//   flush_i      : load a bubble, abandon a running multiply
//   bus          : ID->EX bundle in; EX->MEM register, forwarding value and
//                  multiplier busy out
module ex_stage
    import cpu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     stall_i,
    input  logic     flush_i,
    ex_stage_if.slave bus
);
    logic [DAT_WIDTH-1:0]   in0, in1, sum, diff, result, mul_product;
    logic                   ovf, is_mulu, mul_busy, mul_done, busy, exc;
    logic [ISA_EXP_BUS-1:0] exp_code;
    ex_mem_t                q;

    assign in0     = bus.id_alu_in_0_i;
    assign in1     = bus.id_alu_in_1_i;
    assign sum     = in0 + in1;
    assign diff    = in0 - in1;
    assign is_mulu = bus.id_en_i && (bus.id_alu_op_i == ALU_MULU);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.id_alu_op_i)
            ALU_AND:  result = in0 & in1;
            ALU_OR:   result = in0 | in1;
            ALU_XOR:  result = in0 ^ in1;
            ALU_ADDS: begin
                result = sum;
                ovf    = (in0[31] == in1[31]) && (sum[31] != in0[31]);
            end
            ALU_ADDU: result = sum;
            ALU_SUBS: begin
                result = diff;
                ovf    = (in0[31] != in1[31]) && (diff[31] != in0[31]);
            end
            ALU_SUBU: result = diff;
            ALU_SHRL: result = in0 >> in1[4:0];
            ALU_SHLL: result = in0 << in1[4:0];
            ALU_MULU: result = mul_product;
            default:  result = '0;
        endcase
        ovf = ovf && bus.id_en_i;
    end

    // An upstream exception takes precedence over a locally detected overflow.
    assign exp_code = (bus.id_exp_code_i != EXP_NONE) ? bus.id_exp_code_i :
                      (ovf ? EXP_OVF : EXP_NONE);
    assign exc      = (exp_code != EXP_NONE);

    ex_mul u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (is_mulu),
        .flush   (flush_i),
        .hold    (stall_i),
        .a       (in0),
        .b       (in1),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = is_mulu && mul_busy && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (flush_i) begin
            q <= '0;
        end else if (stall_i) begin
            q <= q;
        end else if (busy) begin
            q <= '0;
        end else begin
            q.pc          <= bus.id_pc_i;
            q.en          <= bus.id_en_i;
            q.br_flag     <= bus.id_br_flag_i;
            q.mem_op      <= (exc || !bus.id_en_i) ? MEM_NOP : bus.id_mem_op_i;
            q.mem_wr_data <= bus.id_mem_wr_data_i;
            q.ctrl_op     <= bus.id_ctrl_op_i;
            q.dst_addr    <= bus.id_dst_addr_i;
            q.gpr_wre     <= bus.id_gpr_wre_i && bus.id_en_i && !exc;
            q.exp_code    <= exp_code;
            q.out         <= result;
        end
    end

    assign bus.exe_fwd_data_o    = result;
    assign bus.exe_busy_o        = busy;
    assign bus.exe_pc_o          = q.pc;
    assign bus.exe_en_o          = q.en;
    assign bus.exe_br_flag_o     = q.br_flag;
    assign bus.exe_mem_op_o      = q.mem_op;
    assign bus.exe_mem_wr_data_o = q.mem_wr_data;
    assign bus.exe_ctrl_op_o     = q.ctrl_op;
    assign bus.exe_dst_addr_o    = q.dst_addr;
    assign bus.exe_gpr_wre_o     = q.gpr_wre;
    assign bus.exe_exp_code_o    = q.exp_code;
    assign bus.exe_out_o         = q.out;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage CPU pipeline: consumes the ID→EX pipeline bundle, evaluates the ALU operation, detects arithmetic overflow, and registers the result into the EX→MEM pipeline register. Provides the combinational forwarding value and the registered destination/enable fields consumed by the decoder's hazard and forwarding logic. Adds a 32-cycle iterative unsigned multiplier that holds upstream stages via a busy request.

## Interface
- ALU_OP_BUS, 4, ALU opcode width
- DAT_WIDTH, 32, datapath width
- ADD_WIDTH, 30, word-address (PC) width
- MEM_OP_BUS, 2, memory opcode width
- CTRL_OP_BUS, 2, control opcode width
- REG_ADD_BUS, 5, register address width
- ISA_EXP_BUS, 3, exception code width

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- stall_i  in  1  hold the EX→MEM register
- flush_i  in  1  discard EX contents, load bubble
- id_pc_i, id_en_i, id_alu_op_i, id_alu_in_0_i, id_alu_in_1_i, id_br_flag_i, id_mem_op_i, id_mem_wr_data_i, id_ctrl_op_i, id_dst_addr_i, id_gpr_wre_i, id_exp_code_i  in  per parameters  ID→EX bundle
- exe_fwd_data_o  out  DAT_WIDTH  combinational result of instruction in EX
- exe_busy_o  out  1  multiplier occupying EX; controller stalls IF/ID and ID/EX
- exe_pc_o, exe_en_o, exe_br_flag_o, exe_mem_op_o, exe_mem_wr_data_o, exe_ctrl_op_o, exe_dst_addr_o, exe_gpr_wre_o, exe_exp_code_o  out  per parameters  EX→MEM register
- exe_out_o  out  DAT_WIDTH  registered ALU/multiplier result

## Operation
- ALU ops: NOP=0 (0), AND=1, OR=2, XOR=3, ADDS=4, ADDU=5, SUBS=6, SUBU=7, SHRL=8 (in_0 >> in_1[4:0]), SHLL=9, MULU=10 (low 32 bits of unsigned product); undefined codes → 0.
- Overflow: ADDS when in_0, in_1 signs equal and result sign differs; SUBS when signs differ and result sign ≠ in_0 sign. Only if id_en_i.
- Exception merge: id_exp_code_i ≠ 0 passes unchanged; else overflow → OVF (3). Any nonzero code forces mem_op=NOP and gpr_wre=0 in the registered bundle.
- Multiplier FSM (ex_mul): IDLE, RUN, DONE.
  - IDLE: id_en_i & op=MULU & !flush_i → latch operands, cnt=0, → RUN.
  - RUN: one shift-add per cycle; cnt==31 → DONE.
  - DONE: product valid; if !stall_i (result captured) → IDLE; else hold.
  - flush_i in any state → IDLE, partial product discarded.
- exe_busy_o = id_en_i & op=MULU & state≠DONE.
- EX→MEM register, priority: rst_i > flush_i > stall_i > exe_busy_o > load.
  - flush: all fields 0 (bubble). stall: hold. busy: load bubble. load: capture bundle with exe_out_o = result.
- exe_en_o=0 implies exe_gpr_wre_o=0, exe_mem_op_o=NOP.

## Timing
- Reset: every registered output 0; FSM IDLE; exe_busy_o 0.
- Single-cycle ops: result in exe_out_o one edge after instruction presented.
- exe_fwd_data_o valid same cycle as the ID→EX bundle (zero latency).
- MULU presented in cycle 0: busy high cycles 0–32, DONE in cycle 33, captured at end of cycle 33 (34 cycles in EX); exe_en_o=0 for cycles 1–33 outputs.
- stall_i during DONE: result held, busy stays 0.
- Simultaneous flush_i and stall_i: flush wins.
- rst_i mid-multiply: immediate bubble, FSM IDLE.

## Structure
- cpu_pkg: ALU, memory, control opcode constants; exception codes (NONE=0, EXT_INT=1, UNDEF=2, OVF=3, MISALIGN=4, TRAP=5, PRIV=6); widths.
- Sub-module ex_mul: iterative multiplier FSM with start/flush/hold in, busy/done/product out.

## Test plan
- ADDS 0x7FFFFFFF+1, en=1, gpr_wre=1 → exe_exp_code_o=3, exe_gpr_wre_o=0, exe_out_o=0x80000000.
- SUBU 5−7 → exe_out_o=0xFFFFFFFE, exp 0; SHLL 1<<31 → 0x80000000; op=15 → 0.
- MULU 0x0001_0003 × 0x0000_0005 → busy 33 cycles, exe_out_o=0x0005_000F, exe_en_o=1 one cycle.
- MULU with flush_i in RUN cycle 10 → busy drops next cycle, bubble registered, FSM IDLE.
- stall_i high 3 cycles with LDW loaded → outputs held; stall+flush same cycle → bubble.
- rst_i asserted asynchronously mid-MULU → all outputs 0 before next edge.
